// File: rtl/cpu_skid_stage.sv
// Registered-ready pipeline stage with a two-entry main/skid store.
// Every output comes straight from a flop, which breaks the stall path toward the producer.
module cpu_skid_stage #(
    parameter int DW = 32
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_flush,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_busy,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    input  logic          i_busy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          acc, pop;

    assign acc = i_valid && !busy_q;
    assign pop = valid_q && !i_busy;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    main_d  = i_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (acc && pop) begin
                    main_d = i_data;
                end else if (acc) begin
                    skid_d  = i_data;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush only invalidates; held words stay in place and are simply forgotten.
        if (i_flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
        valid_d = (state_d != EMPTY);
        busy_d  = (state_d == FULL);
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_data  = main_q;

endmodule

// File: tb/tb_cpu_skid_stage.sv
// Scoreboard bench for cpu_skid_stage: accepted words are queued as expected output,
// and monitors compare every pop, the occupancy-derived flags, and output stability.
module tb_cpu_skid_stage;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          vin = 1'b0;
    logic [DW-1:0] din = '0;
    logic          bin = 1'b0;
    logic          busy_o;
    logic          vout;
    logic [DW-1:0] dout;

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] exp_q[$];
    bit            chk_en = 1'b0;
    bit            snap_ok = 1'b0;
    logic          snap_v, snap_b;
    logic [DW-1:0] snap_d;

    cpu_skid_stage #(.DW(DW)) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .i_flush(flush),
        .i_valid(vin),
        .i_data (din),
        .o_busy (busy_o),
        .o_valid(vout),
        .o_data (dout),
        .i_busy (bin)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    // Drives one cycle of inputs; an accepted word becomes an expected output.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic b,
                         input logic f, input logic r);
        @(posedge clk);
        #2;
        vin = v; din = d; bin = b; flush = f; rst_n = r;
        if (r && !f && v && !busy_o) exp_q.push_back(d);
    endtask

    // Occupancy model: valid iff something is held, busy iff two words are held.
    initial forever begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            check("valid_vs_model", {31'b0, vout}, {31'b0, exp_q.size() > 0});
            check("busy_vs_model", {31'b0, busy_o}, {31'b0, exp_q.size() == 2});
            if (exp_q.size() > 0) check("head_data", dout, exp_q[0]);
            snap_v = vout; snap_b = busy_o; snap_d = dout;
            snap_ok = 1'b1;
        end
    end

    // Mid-cycle: outputs must not have moved with the new inputs; consume pops.
    initial forever begin
        @(negedge clk);
        if (chk_en && snap_ok) begin
            check("no_comb_valid", {31'b0, vout}, {31'b0, snap_v});
            check("no_comb_busy", {31'b0, busy_o}, {31'b0, snap_b});
            check("no_comb_data", dout, snap_d);
            if (vout && !bin) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got %h want nothing at %0t", dout, $time);
                end else begin
                    check("pop_data", dout, exp_q.pop_front());
                end
            end
        end
        if (!rst_n || flush) exp_q.delete();
    end

    initial begin
        // Reset held two cycles with valid asserted.
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        check("rst_valid", {31'b0, vout}, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_data", dout, 32'd0);

        // Streaming at full rate.
        for (int i = 1; i <= 4; i++) drive(1'b1, DW'(i), 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("stream_last", dout, 32'h4);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Stall into skid, then drain without a bubble.
        drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'hB, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 32'hC, 1'b1, 1'b0, 1'b1);
        check("stall_busy", {31'b0, busy_o}, 32'd1);
        drive(1'b1, 32'hC, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b1);
        check("busy_fall", {31'b0, busy_o}, 32'd0);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Flush in FULL alongside a new word.
        drive(1'b1, 32'h11, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 32'h22, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 32'h33, 1'b1, 1'b1, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("flush_empty", {31'b0, vout}, 32'd0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Reset pulse in FULL with downstream stalled.
        drive(1'b1, 32'h44, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 32'h55, 1'b1, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("midrst_valid", {31'b0, vout}, 32'd0);
        check("midrst_busy", {31'b0, busy_o}, 32'd0);
        check("midrst_data", dout, 32'd0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Random traffic with rare flushes.
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(1, 0)), DW'($urandom),
                  1'($urandom_range(2, 0) == 0),
                  1'($urandom_range(99, 0) == 0), 1'b1);
        end

        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
